// File: rtl/inst_loader.sv
// Instruction loader: assembles a length-prefixed little-endian UART byte stream into
// instruction RAM, serves combinational fetches and gates cpu start until a load completes.
module inst_loader #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [31:0]       inst_mem_in,
  output logic [31:0]       inst_mem_out,
  output logic              start,
  output logic              busy,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LEN_HI, DATA, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_len_lo;
  logic [ADDR_W:0] r_n;
  logic [31:0]     r_asm;
  logic [1:0]      r_byte_idx;
  logic            r_wr_pend;
  logic [TW-1:0]   r_tmo;
  logic            r_start;
  logic            r_busy;
  logic            r_err;
  logic [ADDR_W:0] r_words;
  logic [31:0]     r_mem [DEPTH];

  logic [15:0]       w_len;
  logic              w_len_ok;
  logic              w_loading;
  logic              w_tmo_hit;
  logic              w_last_wr;
  logic [ADDR_W-1:0] w_idx;
  logic              w_hi_zero;

  // Header decode, timeout detect and next-state selection
  always_comb begin
    w_len     = {rx_data, r_len_lo};
    w_len_ok  = (w_len != 16'd0) && ({1'b0, w_len} <= 17'(DEPTH));
    w_loading = (r_state == LEN_HI) || (r_state == DATA);
    w_tmo_hit = w_loading && !rx_valid && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    w_last_wr = r_wr_pend && ((r_words + {{ADDR_W{1'b0}}, 1'b1}) == r_n);
    w_next    = r_state;
    case (r_state)
      IDLE: begin
        if (rx_valid) w_next = LEN_HI;
        else          w_next = IDLE;
      end
      LEN_HI: begin
        if (rx_valid)       w_next = w_len_ok ? DATA : IDLE;
        else if (w_tmo_hit) w_next = IDLE;
        else                w_next = LEN_HI;
      end
      DATA: begin
        // completing the final write has priority over both a stray byte and the timer
        if (w_last_wr)      w_next = DONE;
        else if (w_tmo_hit) w_next = IDLE;
        else                w_next = DATA;
      end
      DONE: begin
        if (rx_valid) w_next = LEN_HI;
        else          w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  // FSM state, load bookkeeping and registered status outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_len_lo   <= 8'd0;
      r_n        <= '0;
      r_asm      <= 32'd0;
      r_byte_idx <= 2'd0;
      r_wr_pend  <= 1'b0;
      r_tmo      <= '0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_words    <= '0;
    end else begin
      r_state   <= w_next;
      r_start   <= (w_next == DONE);
      r_busy    <= (w_next == LEN_HI) || (w_next == DATA);
      r_wr_pend <= 1'b0;

      if (w_loading && ((w_next == LEN_HI) || (w_next == DATA)))
        r_tmo <= rx_valid ? '0 : r_tmo + TW'(1);
      else
        r_tmo <= '0;

      if (r_wr_pend)
        r_words <= r_words + {{ADDR_W{1'b0}}, 1'b1};

      case (r_state)
        IDLE, DONE: begin
          if (rx_valid) r_len_lo <= rx_data;
        end
        LEN_HI: begin
          if (rx_valid && w_len_ok) begin
            r_n        <= w_len[ADDR_W:0];
            r_err      <= 1'b0;
            r_words    <= '0;
            r_byte_idx <= 2'd0;
          end else if (rx_valid || w_tmo_hit) begin
            r_err <= 1'b1;
          end
        end
        DATA: begin
          if (w_tmo_hit && !w_last_wr) begin
            r_err <= 1'b1;
          end else if (rx_valid && !w_last_wr) begin
            r_asm[8*r_byte_idx +: 8] <= rx_data;
            r_byte_idx               <= r_byte_idx + 2'd1;
            r_wr_pend                <= (r_byte_idx == 2'd3);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Instruction RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (r_wr_pend) r_mem[r_words[ADDR_W-1:0]] <= r_asm;
  end

  // Fetch path: only loaded, in-range words are visible once the cpu is running
  always_comb begin
    w_idx     = inst_mem_in[ADDR_W+1:2];
    w_hi_zero = ((inst_mem_in >> (ADDR_W + 2)) == 32'd0);
    if (r_start && w_hi_zero && ({1'b0, w_idx} < r_words))
      inst_mem_out = r_mem[w_idx];
    else
      inst_mem_out = 32'h0000_0000;
  end

  assign start        = r_start;
  assign busy         = r_busy;
  assign load_error   = r_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader (short timeout for simulation speed).
module tb_inst_loader;

  localparam int AW = 10;
  localparam int T  = 16;

  logic          clk;
  logic          reset_n;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic [31:0]   inst_mem_in;
  logic [31:0]   inst_mem_out;
  logic          start;
  logic          busy;
  logic          load_error;
  logic [AW:0]   words_loaded;

  int checks   = 0;
  int failures = 0;

  inst_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .inst_mem_in  (inst_mem_in),
    .inst_mem_out (inst_mem_out),
    .start        (start),
    .busy         (busy),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    inst_mem_in = addr;
    #1;
    check(tag, inst_mem_out, exp);
  endtask

  initial begin
    reset_n     = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    inst_mem_in = 32'h0;
    idle(2);
    reset_n = 1'b1;
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, load_error}, 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);

    // two-word program
    send(8'h02);
    check("f1_busy_lenlo", {31'd0, busy}, 32'd1);
    send(8'h00);
    send(8'h13); send(8'h05); send(8'h10); send(8'h00);
    send(8'h93); send(8'h05); send(8'h20); send(8'h00);
    check("f1_start_early", {31'd0, start}, 32'd0);
    tick();
    check("f1_start", {31'd0, start}, 32'd1);
    check("f1_busy_done", {31'd0, busy}, 32'd0);
    check("f1_words", 32'(words_loaded), 32'd2);
    check("f1_err", {31'd0, load_error}, 32'd0);
    fetch("f1_addr0", 32'h0, 32'h0010_0513);
    fetch("f1_addr4", 32'h4, 32'h0020_0593);
    fetch("f1_addr8", 32'h8, 32'h0);
    fetch("f1_addr7", 32'h7, 32'h0020_0593);

    // zero-length header from DONE
    send(8'h00);
    check("z_start_drop", {31'd0, start}, 32'd0);
    check("z_busy", {31'd0, busy}, 32'd1);
    send(8'h00);
    check("z_err", {31'd0, load_error}, 32'd1);
    check("z_busy_idle", {31'd0, busy}, 32'd0);
    check("z_start", {31'd0, start}, 32'd0);
    fetch("z_fetch0", 32'h0, 32'h0);

    // oversize header N = 1025
    send(8'h01); send(8'h04);
    check("big_err", {31'd0, load_error}, 32'd1);
    check("big_busy", {31'd0, busy}, 32'd0);

    // timeout abort mid-word
    send(8'h01);
    check("to_err_sticky", {31'd0, load_error}, 32'd1);
    send(8'h00);
    check("to_err_clr", {31'd0, load_error}, 32'd0);
    check("to_words_clr", 32'(words_loaded), 32'd0);
    send(8'hAA); send(8'hBB);
    idle(T - 1);
    check("to_busy_pre", {31'd0, busy}, 32'd1);
    check("to_err_pre", {31'd0, load_error}, 32'd0);
    idle(1);
    check("to_err", {31'd0, load_error}, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_start", {31'd0, start}, 32'd0);
    check("to_words", 32'(words_loaded), 32'd0);

    // byte on the expiry cycle wins
    send(8'h01); send(8'h00);
    send(8'hAA); send(8'hBB);
    idle(T - 1);
    send(8'hCC);
    check("ex_busy", {31'd0, busy}, 32'd1);
    check("ex_err", {31'd0, load_error}, 32'd0);
    send(8'hDD);
    tick();
    check("ex_start", {31'd0, start}, 32'd1);
    check("ex_words", 32'(words_loaded), 32'd1);
    fetch("ex_addr0", 32'h0, 32'hDDCC_BBAA);
    fetch("ex_addr4_stale", 32'h4, 32'h0);

    // reload from DONE
    send(8'h01);
    check("rl_start_drop", {31'd0, start}, 32'd0);
    fetch("rl_fetch_masked", 32'h0, 32'h0);
    send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    tick();
    check("rl_start", {31'd0, start}, 32'd1);
    fetch("rl_addr0", 32'h0, 32'h4433_2211);

    // reset mid-DATA, then clean reload
    send(8'h02); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mr_start", {31'd0, start}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_words", 32'(words_loaded), 32'd0);
    check("mr_err", {31'd0, load_error}, 32'd0);
    send(8'h01); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    tick();
    check("mr_start_done", {31'd0, start}, 32'd1);
    check("mr_words_done", 32'(words_loaded), 32'd1);
    fetch("mr_addr0", 32'h0, 32'h1234_5678);
    fetch("mr_addr3", 32'h3, 32'h1234_5678);
    fetch("mr_addr4_stale", 32'h4, 32'h0);
    fetch("mr_addr8", 32'h8, 32'h0);
    fetch("mr_addr_hi", 32'h0000_1000, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
